// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the slave's FSM state encodings.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_DATA
    } rstate_t;

endpackage

// File: rtl/sram_1rw_be.sv
// Synchronous single-port DEPTH x 32 RAM with byte enables and 1-cycle read latency.
module sram_1rw_be #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_B = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_B-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_q
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_q;

    // q only moves on a read, so it holds across idle and write cycles
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/axil_dram_slave.sv
// AXI4-Lite slave serving a windowed on-chip data RAM; independent read/write FSMs share one RAM port.
module axil_dram_slave
    import axil_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          DEPTH     = 4096,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = 32'h2000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dram_axi_awaddr,
    input  logic [2:0]        dram_axi_awprot,
    input  logic              dram_axi_awvalid,
    output logic              dram_axi_awready,
    input  logic [DATA_W-1:0] dram_axi_wdata,
    input  logic [3:0]        dram_axi_wstrb,
    input  logic              dram_axi_wvalid,
    output logic              dram_axi_wready,
    output logic [1:0]        dram_axi_bresp,
    output logic              dram_axi_bvalid,
    input  logic              dram_axi_bready,
    input  logic [ADDR_W-1:0] dram_axi_araddr,
    input  logic [2:0]        dram_axi_arprot,
    input  logic              dram_axi_arvalid,
    output logic              dram_axi_arready,
    output logic [DATA_W-1:0] dram_axi_rdata,
    output logic [1:0]        dram_axi_rresp,
    output logic              dram_axi_rvalid,
    input  logic              dram_axi_rready
);

    localparam int unsigned       IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]   WIN_HI = WIN_LO + (ADDR_W+1)'(4 * DEPTH);

    // Extra top bit keeps the upper bound from wrapping near the end of the address space
    function automatic logic in_win(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] x;
        x = {1'b0, a};
        return (x >= WIN_LO) && (x < WIN_HI);
    endfunction

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic              r_aw_held, r_w_held;
    logic [ADDR_W-1:0] r_awaddr, r_araddr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_bvalid, r_rvalid;
    logic [1:0]        r_bresp, r_rresp;
    logic [DATA_W-1:0] r_rdata;

    logic              w_aw_hs, w_w_hs, w_ar_hs;
    logic              w_aw_in_win, w_ar_in_win;
    logic [ADDR_W-1:0] w_aw_off, w_ar_off;
    logic              w_commit, w_ram_wr, w_ram_rd;
    logic [IDX_W-1:0]  w_ram_addr;
    logic [31:0]       w_ram_q;
    logic              w_unused;

    assign dram_axi_awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign dram_axi_wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign dram_axi_arready = (r_rstate == R_IDLE);

    assign w_aw_hs = dram_axi_awvalid && dram_axi_awready;
    assign w_w_hs  = dram_axi_wvalid && dram_axi_wready;
    assign w_ar_hs = dram_axi_arvalid && dram_axi_arready;

    assign w_aw_in_win = in_win(r_awaddr);
    assign w_ar_in_win = in_win(r_araddr);
    assign w_aw_off    = r_awaddr - BASE_ADDR;
    assign w_ar_off    = r_araddr - BASE_ADDR;

    // The commit owns the RAM port; a read issuing in the same cycle waits one cycle
    assign w_commit   = (r_wstate == W_COMMIT);
    assign w_ram_wr   = w_commit && w_aw_in_win;
    assign w_ram_rd   = (r_rstate == R_ISSUE) && !w_commit && w_ar_in_win;
    assign w_ram_addr = w_ram_wr ? w_aw_off[IDX_W+1:2] : w_ar_off[IDX_W+1:2];

    assign w_unused = ^{dram_axi_awprot, dram_axi_arprot,
                        w_aw_off[1:0], w_aw_off[ADDR_W-1:IDX_W+2],
                        w_ar_off[1:0], w_ar_off[ADDR_W-1:IDX_W+2]};

    sram_1rw_be #(
        .DEPTH  (DEPTH),
        .ADDR_B (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_wr || w_ram_rd),
        .i_we    (w_ram_wr),
        .i_be    (r_wstrb),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_q     (w_ram_q)
    );

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:   if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wstate_nxt = W_COMMIT;
            W_COMMIT: w_wstate_nxt = W_RESP;
            W_RESP:   if (dram_axi_bready) w_wstate_nxt = W_IDLE;
            default:  w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_ISSUE;
            R_ISSUE: if (!w_commit) w_rstate_nxt = R_WAIT;
            R_WAIT:  w_rstate_nxt = R_DATA;
            R_DATA:  if (dram_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) r_aw_held <= 1'b1;
            if (w_w_hs)  r_w_held  <= 1'b1;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_in_win ? RESP_OKAY : RESP_SLVERR;
            end
            if ((r_wstate == W_RESP) && dram_axi_bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (r_rstate == R_WAIT) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_ar_in_win ? RESP_OKAY : RESP_SLVERR;
                r_rdata  <= w_ar_in_win ? w_ram_q : '0;
            end
            if ((r_rstate == R_DATA) && dram_axi_rready) r_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs) r_awaddr <= dram_axi_awaddr;
        if (w_ar_hs) r_araddr <= dram_axi_araddr;
        if (w_w_hs) begin
            r_wdata <= dram_axi_wdata;
            r_wstrb <= dram_axi_wstrb;
        end
    end

    assign dram_axi_bvalid = r_bvalid;
    assign dram_axi_bresp  = r_bresp;
    assign dram_axi_rvalid = r_rvalid;
    assign dram_axi_rresp  = r_rresp;
    assign dram_axi_rdata  = r_rdata;

endmodule

// File: doc/axil_dram_slave.md
Name: axil_dram_slave

Overview:
AXI4-Lite slave that terminates the core's master data port (core_axi_*) and serves it from an on-chip single-port, byte-writable data RAM.
- Read and write channels are handled by independent FSMs that share one RAM port.
- Writes win on a same-cycle conflict.
- Addresses outside the RAM window complete with SLVERR and have no side effects.

Parameters:
ADDR_W, 32, AXI address width (matches MemAddrBus)
DATA_W, 32, AXI data width (matches MemBus); fixed 32, 4 strobe bits
DEPTH, 4096, RAM depth in 32-bit words (power of two)
BASE_ADDR, 32'h2000_0000, byte address of word 0; window = BASE_ADDR .. BASE_ADDR+4*DEPTH-1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
dram_axi_awaddr  in  ADDR_W  write address
dram_axi_awprot  in  3  ignored
dram_axi_awvalid  in  1  write address valid
dram_axi_awready  out  1  write address ready
dram_axi_wdata  in  DATA_W  write data
dram_axi_wstrb  in  4  byte strobes
dram_axi_wvalid  in  1  write data valid
dram_axi_wready  out  1  write data ready
dram_axi_bresp  out  2  00 OKAY, 10 SLVERR
dram_axi_bvalid  out  1  write response valid
dram_axi_bready  in  1  write response ready
dram_axi_araddr  in  ADDR_W  read address
dram_axi_arprot  in  3  ignored
dram_axi_arvalid  in  1  read address valid
dram_axi_arready  out  1  read address ready
dram_axi_rdata  out  DATA_W  read data
dram_axi_rresp  out  2  00 OKAY, 10 SLVERR
dram_axi_rvalid  out  1  read data valid
dram_axi_rready  in  1  read data ready

Behaviour:
- Reset (rst_n low at an edge):
  - Write FSM goes to W_IDLE, read FSM to R_IDLE, aw_held/w_held cleared.
  - bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0.
  - RAM contents are not cleared.
  - A reset mid-transaction drops the transaction; a partially latched AW/W is discarded.
- Readys are combinational from state: awready = W_IDLE & ~aw_held; wready = W_IDLE & ~w_held; arready = (R_IDLE).
- Write FSM: W_IDLE -> W_COMMIT -> W_RESP -> W_IDLE.
  - W_IDLE: AW and W are accepted independently, in either order or together; each is latched on its handshake. Once both are held, go to W_COMMIT.
  - W_COMMIT (one cycle): if the address is in the window, write the RAM at word index (addr-BASE_ADDR)>>2 under wstrb and set bresp=00. Otherwise do no write and set bresp=10. Go to W_RESP with bvalid=1.
  - W_RESP: hold bvalid/bresp until bready. On the handshake edge, set bvalid=0, clear held flags, go to W_IDLE.
  - Latency: AW+W together at edge E0 -> commit in cycle after E0 -> bvalid high from E1.
  - wstrb=0000 is OKAY with no write.
- Read FSM: R_IDLE -> R_ISSUE -> R_WAIT -> R_DATA -> R_IDLE.
  - R_IDLE: on the AR handshake, latch the address and go to R_ISSUE.
  - R_ISSUE: if the write FSM is in W_COMMIT this cycle, stall (stay) without enabling the RAM. Otherwise enable the RAM read and go to R_WAIT.
  - R_WAIT: at the next edge, capture RAM q into rdata and set rvalid=1, rresp=00. Out-of-window addresses skip the RAM: rdata=0, rresp=10.
  - R_DATA: hold rdata/rresp/rvalid stable until rready. On the handshake edge, set rvalid=0 and go to R_IDLE.
  - Latency: AR at E0 -> rvalid from E2 with no conflict, E3 with one write conflict.
- Addressing: awaddr/araddr bits [1:0] are ignored (word aligned). The window check is on the full ADDR_W with no wrap-around; BASE_ADDR+4*DEPTH and above is out of window.
- Ordering: reads and writes are unordered relative to each other, except that a read whose issue coincides with a write commit sees the new data.
- Outstanding transactions: at most 1 write and 1 read. AW/W/AR stay not-ready until the previous response has handshaken.

Decomposition:
- Shared package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - write state encoding (W_IDLE, W_COMMIT, W_RESP)
  - read state encoding (R_IDLE, R_ISSUE, R_WAIT, R_DATA)
- One sub-module, sram_1rw_be: synchronous single-port RAM with DEPTH x 32 bits, en/we/4-bit byte-enable, and 1-cycle read latency. q holds its value when en=0.

Test Plan:
- AW(0x2000_0010) and W(0xDEADBEEF, strb 1111) in the same cycle, bready=1 -> bvalid one cycle later with bresp=00. Then AR(0x2000_0010) -> rvalid 2 cycles after the AR handshake, rdata=0xDEADBEEF, rresp=00.
- W presented 3 cycles before AW, then a strb-0010 write of 0x0000_5500 over the 0xDEADBEEF word -> readback 0xDEAD55EF. awready/wready each drop after their own handshake.
- Write to BASE_ADDR+4*DEPTH -> bresp=10, RAM unchanged (prior word readback intact). Read of 0x0000_0000 -> rresp=10, rdata=0.
- AR issue coincides with W_COMMIT to the same address (new 0x1234_5678) -> read stalls one cycle (rvalid at E3) and returns 0x1234_5678.
- Backpressure: bready and rready held low for 5 cycles -> bvalid/rvalid, bresp/rresp and rdata stay stable; no new AW/W/AR accepted until the handshakes complete.
- rst_n low for one edge while in R_WAIT and W_RESP -> next cycle rvalid=0, bvalid=0, all readys=1, and a subsequent full write/read succeeds.
